// File: rtl/ysyx_24080006_mdu_pkg.sv
// Shared types for the EX-stage multiply/divide unit and its ALU adder link.
// The optional MDU_EARLY_OUT_EN macro is consumed by ysyx_24080006_mdu.
package ysyx_24080006_mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULL = 2'd0,
        MDU_MULH = 2'd1,
        MDU_DIV  = 2'd2,
        MDU_REM  = 2'd3
    } mdu_op_e;

    typedef struct packed {
        logic    mdu_enable;
        mdu_op_e op;
        logic    signed_a;
        logic    signed_b;
    } mdu_set_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic [32:0] a;
        logic [32:0] b;
    } mdu2alu_t;

    typedef struct packed {
        logic [33:0] res_34;
        logic [31:0] res_32;
        logic        not_zero;
    } alu2mdu_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DABS = 3'd2,
        DIV  = 3'd3,
        DFIX = 3'd4,
        DONE = 3'd5
    } mdu_state_e;

    localparam int MduIter    = 32;
    localparam int MulLatency = 33;
    localparam int DivLatency = 37;

    // RISC-V divide-by-zero and signed-overflow results override the datapath value
    function automatic logic [31:0] mdu_fixup(input logic is_div, input logic dz, input logic ovf,
                                              input logic [31:0] dividend, input logic [31:0] value);
        logic [31:0] r;
        if (dz) begin
            r = is_div ? 32'hFFFF_FFFF : dividend;
        end else if (ovf) begin
            r = is_div ? 32'h8000_0000 : 32'h0000_0000;
        end else begin
            r = value;
        end
        return r;
    endfunction

endpackage

// File: rtl/ysyx_24080006_mdu.sv
// Iterative RV32M multiply/divide unit sharing the ALU's 34-bit adder.
// Define MDU_EARLY_OUT_EN to finish trivial operations one cycle after accept.
module ysyx_24080006_mdu
    import ysyx_24080006_mdu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  mdu_set_t    mdu_set,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    output logic        alu_req,
    output alu_op_e     alu_op,
    output mdu2alu_t    mdu2alu,
    input  alu2mdu_t    alu2mdu,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    mdu_state_e  state_r, state_nxt_s;
    logic [4:0]  cnt_r;
    mdu_op_e     op_r;
    logic        sa_r, sb_r;
    logic [31:0] a_r, b_r, lo_r, result_r;
    logic [32:0] hi_r;
    logic        q_neg_r, r_neg_r, dz_r, ovf_r;
    logic        accept_s, last_s, is_mul_s, is_div_s, neg_a_s, neg_b_s, ovf_in_s;
    logic [32:0] a_ext_s;
`ifdef MDU_EARLY_OUT_EN
    logic        early_s;
    logic [31:0] early_res_s;
`endif

    assign accept_s  = in_valid && (state_r == IDLE);
    assign last_s    = (cnt_r == 5'(MduIter - 1));
    assign is_mul_s  = (mdu_set.op == MDU_MULL) || (mdu_set.op == MDU_MULH);
    assign is_div_s  = (op_r == MDU_DIV);
    assign neg_a_s   = sa_r & a_r[31];
    assign neg_b_s   = sb_r & b_r[31];
    assign a_ext_s   = {neg_a_s, a_r};
    assign ovf_in_s  = mdu_set.signed_a && mdu_set.signed_b &&
                       (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);

`ifdef MDU_EARLY_OUT_EN
    assign early_s     = is_mul_s ? ((rs1_data == 32'd0) || (rs2_data == 32'd0))
                                  : ((rs2_data == 32'd0) || ovf_in_s);
    assign early_res_s = is_mul_s ? 32'd0
                                  : mdu_fixup(mdu_set.op == MDU_DIV, rs2_data == 32'd0, ovf_in_s,
                                              rs1_data, 32'd0);
`endif

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign result    = result_r;

    // Next-state selection; flush overrides every transition including the output handshake
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
`ifdef MDU_EARLY_OUT_EN
                    if (early_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = is_mul_s ? MUL : DABS;
                    end
`else
                    state_nxt_s = is_mul_s ? MUL : DABS;
`endif
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MUL:     state_nxt_s = last_s   ? DONE : MUL;
            DABS:    state_nxt_s = cnt_r[0] ? DIV  : DABS;
            DIV:     state_nxt_s = last_s   ? DFIX : DIV;
            DFIX:    state_nxt_s = cnt_r[0] ? DONE : DFIX;
            DONE:    state_nxt_s = out_ready ? IDLE : DONE;
            default: state_nxt_s = IDLE;
        endcase
        if (flush) begin
            state_nxt_s = IDLE;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // Adder requests: the partial remainder keeps 33 bits, so a modulo-2^33 shift-in is exact
    always_comb begin
        alu_req   = 1'b0;
        alu_op    = ALU_ADD;
        mdu2alu   = '0;
        case (state_r)
            MUL: begin
                alu_req   = 1'b1;
                mdu2alu.a = hi_r;
                mdu2alu.b = lo_r[0] ? a_ext_s : 33'd0;
                alu_op    = (last_s && sb_r) ? ALU_SUB : ALU_ADD;
            end
            DABS: begin
                alu_req   = 1'b1;
                mdu2alu.a = 33'd0;
                if (cnt_r[0]) begin
                    mdu2alu.b = {neg_b_s, b_r};
                    alu_op    = neg_b_s ? ALU_SUB : ALU_ADD;
                end else begin
                    mdu2alu.b = a_ext_s;
                    alu_op    = neg_a_s ? ALU_SUB : ALU_ADD;
                end
            end
            DIV: begin
                alu_req   = 1'b1;
                mdu2alu.a = {hi_r[31:0], lo_r[31]};
                mdu2alu.b = {1'b0, b_r};
                alu_op    = hi_r[32] ? ALU_ADD : ALU_SUB;
            end
            DFIX: begin
                alu_req = 1'b1;
                if (cnt_r[0]) begin
                    mdu2alu.a = 33'd0;
                    mdu2alu.b = {1'b0, is_div_s ? lo_r : hi_r[31:0]};
                    alu_op    = (is_div_s ? q_neg_r : r_neg_r) ? ALU_SUB : ALU_ADD;
                end else begin
                    mdu2alu.a = hi_r;
                    mdu2alu.b = hi_r[32] ? {1'b0, b_r} : 33'd0;
                    alu_op    = ALU_ADD;
                end
            end
            default: begin
                alu_req = 1'b0;
            end
        endcase
    end

    // State, iteration counter and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= IDLE;
            cnt_r    <= 5'd0;
            op_r     <= MDU_MULL;
            sa_r     <= 1'b0;
            sb_r     <= 1'b0;
            a_r      <= 32'd0;
            b_r      <= 32'd0;
            lo_r     <= 32'd0;
            hi_r     <= 33'd0;
            result_r <= 32'd0;
            q_neg_r  <= 1'b0;
            r_neg_r  <= 1'b0;
            dz_r     <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= (state_nxt_s != state_r) ? 5'd0 : cnt_r + 5'd1;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r  <= mdu_set.op;
                        sa_r  <= mdu_set.signed_a;
                        sb_r  <= mdu_set.signed_b;
                        a_r   <= rs1_data;
                        b_r   <= rs2_data;
                        lo_r  <= rs2_data;
                        hi_r  <= 33'd0;
                        ovf_r <= ovf_in_s;
`ifdef MDU_EARLY_OUT_EN
                        if (early_s) begin
                            result_r <= early_res_s;
                        end
`endif
                    end
                end
                MUL: begin
                    hi_r <= alu2mdu.res_34[33:1];
                    lo_r <= {alu2mdu.res_34[0], lo_r[31:1]};
                    if (last_s) begin
                        result_r <= (op_r == MDU_MULL) ? {alu2mdu.res_34[0], lo_r[31:1]}
                                                       : alu2mdu.res_34[32:1];
                    end
                end
                DABS: begin
                    if (cnt_r[0]) begin
                        b_r     <= alu2mdu.res_32;
                        dz_r    <= ~alu2mdu.not_zero;
                        q_neg_r <= neg_a_s ^ neg_b_s;
                        r_neg_r <= neg_a_s;
                    end else begin
                        lo_r <= alu2mdu.res_32;
                        hi_r <= 33'd0;
                    end
                end
                DIV: begin
                    hi_r <= alu2mdu.res_34[32:0];
                    lo_r <= {lo_r[30:0], ~alu2mdu.res_34[32]};
                end
                DFIX: begin
                    if (cnt_r[0]) begin
                        result_r <= mdu_fixup(is_div_s, dz_r, ovf_r, a_r, alu2mdu.res_32);
                    end else begin
                        hi_r <= alu2mdu.res_34[32:0];
                    end
                end
                default: begin
                    hi_r <= hi_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24080006_mdu.sv
// Self-checking bench for ysyx_24080006_mdu: directed RV32M cases plus random ops
// against a 64-bit arithmetic reference; models the external ALU adder.
module tb_ysyx_24080006_mdu;
    import ysyx_24080006_mdu_pkg::*;

    logic        clock = 1'b0;
    logic        reset, in_valid, in_ready, flush, alu_req, out_valid, out_ready;
    mdu_set_t    mdu_set;
    logic [31:0] rs1_data, rs2_data, result;
    alu_op_e     alu_op;
    mdu2alu_t    mdu2alu;
    alu2mdu_t    alu2mdu;

    int n_tests = 0;
    int n_fail  = 0;
    int bad_ops = 0;

    always #5 clock = ~clock;

    ysyx_24080006_mdu dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .mdu_set(mdu_set), .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .alu_req(alu_req), .alu_op(alu_op), .mdu2alu(mdu2alu), .alu2mdu(alu2mdu),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    // External ALU adder: sign-extend both 33-bit operands to 34 bits
    always_comb begin
        logic [33:0] sa34, sb34;
        sa34 = {mdu2alu.a[32], mdu2alu.a};
        sb34 = {mdu2alu.b[32], mdu2alu.b};
        alu2mdu.res_34   = (alu_op == ALU_SUB) ? sa34 - sb34 : sa34 + sb34;
        alu2mdu.res_32   = alu2mdu.res_34[31:0];
        alu2mdu.not_zero = |alu2mdu.res_34[31:0];
    end

    always @(negedge clock) begin
        if (alu_req && (alu_op != ALU_ADD) && (alu_op != ALU_SUB)) bad_ops++;
    end

    task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input mdu_op_e op, input logic sa, input logic sb,
                                              input logic [31:0] a, input logic [31:0] b);
        longint ea, eb, p;
        ea = sa ? longint'($signed(a)) : longint'(a);
        eb = sb ? longint'($signed(b)) : longint'(b);
        p  = ea * eb;
        case (op)
            MDU_MULL: return p[31:0];
            MDU_MULH: return p[63:32];
            default: begin
                if (b == 32'd0) return (op == MDU_DIV) ? 32'hFFFF_FFFF : a;
                if (sa && sb && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return (op == MDU_DIV) ? 32'h8000_0000 : 32'd0;
                p = (op == MDU_DIV) ? ea / eb : ea % eb;
                return p[31:0];
            end
        endcase
    endfunction

    function automatic int exp_latency(input mdu_op_e op, input logic sa, input logic sb,
                                       input logic [31:0] a, input logic [31:0] b);
        logic is_mul;
        is_mul = (op == MDU_MULL) || (op == MDU_MULH);
`ifdef MDU_EARLY_OUT_EN
        if (is_mul && (a == 32'd0 || b == 32'd0)) return 1;
        if (!is_mul && (b == 32'd0 || (sa && sb && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
`endif
        return is_mul ? MulLatency : DivLatency;
    endfunction

    task automatic issue(input mdu_op_e op, input logic sa, input logic sb,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        in_valid = 1'b1;
        mdu_set.mdu_enable = 1'b1;
        mdu_set.op = op;
        mdu_set.signed_a = sa;
        mdu_set.signed_b = sb;
        rs1_data = a;
        rs2_data = b;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_op(input string tag, input mdu_op_e op, input logic sa, input logic sb,
                         input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] exp, held;
        int lat;
        exp = ref_model(op, sa, sb, a, b);
        chk({tag, " in_ready"}, in_ready, 1'b1);
        issue(op, sa, sb, a, b);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
        chk({tag, " latency"}, lat, exp_latency(op, sa, sb, a, b));
        chk({tag, " result"}, result, exp);
        held = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1;
            chk({tag, " hold result"}, result, held);
            chk({tag, " hold valid"}, out_valid, 1'b1);
            chk({tag, " hold in_ready"}, in_ready, 1'b0);
        end
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        chk({tag, " post-hs in_ready"}, in_ready, 1'b1);
        chk({tag, " post-hs valid"}, out_valid, 1'b0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " in_ready"}, in_ready, 1'b1);
        chk({tag, " out_valid"}, out_valid, 1'b0);
        chk({tag, " alu_req"}, alu_req, 1'b0);
        chk({tag, " alu_op"}, alu_op, ALU_ADD);
        chk({tag, " mdu2alu"}, mdu2alu, 66'd0);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] edges [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        case ($urandom_range(0, 3))
            0:       return edges[$urandom_range(0, 4)];
            1:       return 32'($signed($urandom_range(0, 40)) - 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int seen;
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        mdu_set = '0; rs1_data = 32'd0; rs2_data = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk_idle_outputs("reset");
        chk("reset result", result, 32'd0);

        do_op("mull 7*-3", MDU_MULL, 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFD, 0);
        chk("mull 7*-3 const", ref_model(MDU_MULL, 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        do_op("mulh", MDU_MULH, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 0);
        do_op("mulhu", MDU_MULH, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 0);
        do_op("mulhsu", MDU_MULH, 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 0);
        do_op("div -7/2", MDU_DIV, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        do_op("rem -7/2", MDU_REM, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        do_op("div 5/0", MDU_DIV, 1'b1, 1'b1, 32'd5, 32'd0, 0);
        do_op("rem 5/0", MDU_REM, 1'b1, 1'b1, 32'd5, 32'd0, 0);
        do_op("div ovf", MDU_DIV, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op("rem ovf", MDU_REM, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op("divu big", MDU_DIV, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 0);
        do_op("backpressure", MDU_MULL, 1'b0, 1'b0, 32'd12345, 32'd678, 5);

        // Flush during the tenth divide iteration
        issue(MDU_DIV, 1'b1, 1'b1, 32'd1000, 32'd7);
        repeat (12) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        chk("flush in_ready", in_ready, 1'b1);
        chk("flush out_valid", out_valid, 1'b0);
        chk("flush alu_req", alu_req, 1'b0);
        seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (out_valid) seen++;
        end
        chk("flush no valid", seen, 0);

        // Reset during the twentieth multiply iteration
        issue(MDU_MULH, 1'b1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (20) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk_idle_outputs("midreset");
        chk("midreset result", result, 32'd0);
        do_op("after reset", MDU_MULH, 1'b1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 0);

        for (int i = 0; i < 40; i++) begin
            mdu_op_e op;
            logic sa, sb;
            op = mdu_op_e'($urandom_range(0, 3));
            sa = 1'($urandom);
            sb = (op == MDU_DIV || op == MDU_REM) ? sa : 1'($urandom);
            do_op("random", op, sa, sb, rand_operand(), rand_operand(), i % 3);
        end

        chk("alu op legal", bad_ops, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_24080006_mdu.md
Name: ysyx_24080006_mdu

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, alongside the ALU.
- Takes the decoded `mdu_set_t` and the rs1/rs2 operands when the EX stage issues an MDU instruction.
- Performs every add/subtract on the ALU's 34-bit adder through `mdu2alu_t`/`alu2mdu_t`, and returns the 32-bit result to the EX/WB path with a valid/ready handshake.

Parameters:
- None; data width is fixed at 32.

Ports:
- `clock`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  EX presents an MDU operation
- `in_ready`  out  1  MDU can accept (state IDLE)
- `mdu_set`  in  `mdu_set_t`  op, signed_a, signed_b (`mdu_enable` must be 1 when `in_valid`)
- `rs1_data`  in  32  operand A / dividend
- `rs2_data`  in  32  operand B / divisor
- `flush`  in  1  kill any in-flight operation
- `alu_req`  out  1  MDU owns the ALU adder this cycle
- `alu_op`  out  `alu_op_e`  ALU_ADD or ALU_SUB only
- `mdu2alu`  out  `mdu2alu_t`  33-bit operands a, b
- `alu2mdu`  in  `alu2mdu_t`  `res_34` = sext34(a) ± sext34(b) (combinational), `res_32`, `not_zero`
- `out_valid`  out  1  result available
- `out_ready`  in  1  downstream accepts result
- `result`  out  32  rd write data

Behaviour:
- Reset values: state IDLE; `in_ready`=1; `out_valid`=0; `alu_req`=0; `result`=0; `mdu2alu`=0; `alu_op`=ALU_ADD.
- Accept occurs on `in_valid && in_ready`. Operands and set are latched; `in_ready` drops the next cycle.
- States: IDLE, MUL, DABS, DIV, DFIX, DONE.
  - IDLE → MUL: on accept with op MULL or MULH.
  - IDLE → DABS: on accept with op DIV or REM.
- MUL (32 cycles, counter 0..31):
  - Accumulator is {hi 33b, lo 32b}.
  - Each cycle: if lo[0], hi ± sext33(A) via the ALU. Use SUB only on the last step when `signed_b`; otherwise ADD.
  - Then arithmetic-shift {res_34[32:0], lo} right by 1.
  - A is sign-extended when `signed_a`, zero-extended otherwise.
  - → DONE. MULL result = lo; MULH result = hi[31:0]. This covers MULH, MULHSU and MULHU.
- DABS (2 cycles):
  - Cycle 1: |dividend| via ALU 0-x.
  - Cycle 2: |divisor| via ALU 0-x.
  - Negation happens only when `signed_a` and bit31=1.
  - Record the quotient sign, the remainder sign, and divisor-zero (`not_zero`=0 on the divisor read).
- DIV (32 cycles):
  - Non-restoring, one ALU add/sub per cycle on the 33-bit partial remainder.
  - Quotient bit = ~res_34[32].
- DFIX (2 cycles):
  - Cycle 1: restore a negative remainder (+divisor).
  - Cycle 2: negate the quotient or remainder per the recorded sign (0-x). Skip the negation in value only; the cycle count is unchanged.
  - → DONE.
- Fixed latency from the accept edge to `out_valid`=1: MUL 33 cycles; DIV/REM 37 cycles.
- DONE:
  - `out_valid`=1 and `result` held stable until `out_ready`.
  - On the handshake cycle → IDLE; `in_ready`=1 the following cycle.
  - No accept is allowed in the same cycle as the handshake.
- Boundary cases (RISC-V spec):
  - Divide by zero: DIV → 0xFFFF_FFFF; REM → dividend.
  - Signed overflow 0x8000_0000 / -1: DIV → 0x8000_0000; REM → 0.
  - Both are produced by the normal datapath plus forced overrides in DFIX; latency is unchanged.
- `alu_req`=1 in MUL, DABS, DIV and DFIX only. While it is high, the ALU must ignore the EX operands.
- `flush` in any state → IDLE next cycle, with `out_valid`=0 and `alu_req`=0. `flush` has priority over accept and over the output handshake.
- `reset` mid-operation behaves the same as flush, and all outputs return to their reset values.

Optional Feature:
- `MDU_EARLY_OUT_EN`
- When defined: IDLE goes directly to DONE (`out_valid` 1 cycle after accept) in these cases:
  - rs2==0 for DIV/REM;
  - signed overflow;
  - either operand ==0 for MUL.
  - The result is the spec value, and the ALU is never requested.
- When undefined: the fixed latencies above always apply.

Decomposition:
- Shared package gets:
  - `mdu_state_e` {IDLE, MUL, DABS, DIV, DFIX, DONE}.
  - `localparam MduIter = 32`.
  - `MulLatency = 33` and `DivLatency = 37` for the bench.
  - The existing `mdu_set_t`, `mdu_op_e`, `mdu2alu_t` and `alu2mdu_t` are reused unchanged.
- The block is a single module; no sub-module is needed because the adder is external.

Test Plan:
- MULL 7 × -3 (signed/signed):
  - ALU model adds/subs; `out_valid` exactly 33 cycles after accept; result 0xFFFF_FFEB.
- MULH variants, 0x8000_0000 × 0x8000_0000:
  - MULH → 0x4000_0000.
  - MULHU → 0x4000_0000.
  - MULHSU (A signed) → 0xC000_0000.
- DIV -7/2 → 0xFFFF_FFFD; REM -7/2 → 0xFFFF_FFFF; each at 37 cycles.
- Edge divides:
  - DIV 5/0 → 0xFFFF_FFFF; REM 5/0 → 5.
  - DIV 0x8000_0000/-1 → 0x8000_0000; REM → 0.
  - With `MDU_EARLY_OUT_EN`, each completes in 1 cycle.
- Back-pressure: hold `out_ready`=0 for 5 cycles in DONE.
  - `result` and `out_valid` stay stable; `in_ready`=0.
  - Handshake → `in_ready`=1 the next cycle.
- Abort cases:
  - Assert `flush` at DIV iteration 10 → IDLE next cycle; no `out_valid`.
  - Reset at MUL iteration 20 → all outputs at reset values; a new op then completes correctly.
